// File: rtl/sram_march_bist.sv
// sram_march_bist: BIST engine for NUM_SRAMS lockstep SRAM macros.
// Runs a write/read sweep (mode 0) or a March C- sweep (mode 1). It reports
// a sticky per-macro fail vector, the first failing address and a saturating
// error count, and signals done/pass when the run completes.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | no run; waits for start_i
// ST_W0    | ascending, write P
// ST_R0W1  | ascending, read (expect P) then write ~P per address
// ST_R1W0  | descending, read (expect ~P) then write P per address
// ST_R0    | ascending, read (expect P)
// ST_DRAIN | no ops; waits READ_LATENCY cycles for the last compares
// ST_DONE  | results valid; waits for start_i
module sram_march_bist #(
    parameter int ADDR_WIDTH   = 8,
    parameter int DATA_WIDTH   = 32,
    parameter int NUM_SRAMS    = 2,
    parameter int READ_LATENCY = 1
) (
    input  logic                            wb_clk_i,
    input  logic                            wb_rst_i,
    input  logic                            start_i,
    input  logic                            abort_i,
    input  logic                            mode_i,
    input  logic [DATA_WIDTH-1:0]           pattern_i,
    output logic                            sram_csb0,
    output logic                            sram_web0,
    output logic [ADDR_WIDTH-1:0]           sram_addr0,
    output logic [DATA_WIDTH-1:0]           sram_din0,
    input  logic [NUM_SRAMS*DATA_WIDTH-1:0] sram_dout,
    output logic                            busy_o,
    output logic                            done_o,
    output logic                            pass_o,
    output logic [NUM_SRAMS-1:0]            fail_vec_o,
    output logic [ADDR_WIDTH-1:0]           fail_addr_o,
    output logic [15:0]                     err_count_o
);

    localparam int LAT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_W0,
        ST_R0W1,
        ST_R1W0,
        ST_R0,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                    phase_q, phase_d;   // 0 = read slot, 1 = write slot
    logic                    mode_q, mode_d;
    logic [DATA_WIDTH-1:0]   pattern_q, pattern_d;
    logic [LAT_W-1:0]        drain_q, drain_d;

    logic                    csb_q, csb_d;
    logic                    web_q, web_d;
    logic [DATA_WIDTH-1:0]   din_q, din_d;

    logic [READ_LATENCY-1:0] pipe_vld_q, pipe_vld_d;
    logic [DATA_WIDTH-1:0]   pipe_exp_q  [READ_LATENCY];
    logic [DATA_WIDTH-1:0]   pipe_exp_d  [READ_LATENCY];
    logic [ADDR_WIDTH-1:0]   pipe_addr_q [READ_LATENCY];
    logic [ADDR_WIDTH-1:0]   pipe_addr_d [READ_LATENCY];

    logic [NUM_SRAMS-1:0]    fail_vec_q, fail_vec_d;
    logic [ADDR_WIDTH-1:0]   fail_addr_q, fail_addr_d;
    logic [15:0]             err_q, err_d;

    logic                    busy;
    logic                    start_now;
    logic                    abort_now;
    logic                    rd_now;
    logic [DATA_WIDTH-1:0]   exp_now;
    logic                    cmp_vld;
    logic [NUM_SRAMS-1:0]    miss;
    logic [16:0]             miss_cnt;
    logic [16:0]             err_sum;

    assign busy      = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign start_now = !busy && start_i;
    assign abort_now = busy && abort_i;

    // Next-state and address sequencing; the op for the next cycle is decoded from the result.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        phase_d   = phase_q;
        mode_d    = mode_q;
        pattern_d = pattern_q;
        drain_d   = drain_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_i) begin
                    state_d   = ST_W0;
                    addr_d    = '0;
                    phase_d   = 1'b0;
                    mode_d    = mode_i;
                    pattern_d = pattern_i;
                end
            end
            ST_W0: begin
                if (addr_q == ADDR_MAX) begin
                    addr_d  = '0;
                    phase_d = 1'b0;
                    state_d = mode_q ? ST_R0W1 : ST_R0;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            ST_R0W1: begin
                if (!phase_q) begin
                    phase_d = 1'b1;
                end else begin
                    phase_d = 1'b0;
                    if (addr_q == ADDR_MAX) begin
                        // descending element starts on the same top address
                        state_d = ST_R1W0;
                    end else begin
                        addr_d = addr_q + 1'b1;
                    end
                end
            end
            ST_R1W0: begin
                if (!phase_q) begin
                    phase_d = 1'b1;
                end else begin
                    phase_d = 1'b0;
                    if (addr_q == '0) begin
                        state_d = ST_R0;
                    end else begin
                        addr_d = addr_q - 1'b1;
                    end
                end
            end
            ST_R0: begin
                if (addr_q == ADDR_MAX) begin
                    state_d = ST_DRAIN;
                    drain_d = LAT_W'(READ_LATENCY - 1);
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                if (drain_q == '0) begin
                    state_d = ST_DONE;
                    addr_d  = '0;
                end else begin
                    drain_d = drain_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                addr_d  = '0;
            end
        endcase
        if (abort_now) begin
            state_d = ST_IDLE;
            addr_d  = '0;
            phase_d = 1'b0;
        end
    end

    // Decode the SRAM op for the state being entered so the port registers line up with it.
    always_comb begin
        csb_d = 1'b1;
        web_d = 1'b1;
        din_d = '0;
        case (state_d)
            ST_W0: begin
                csb_d = 1'b0;
                web_d = 1'b0;
                din_d = pattern_d;
            end
            ST_R0W1: begin
                csb_d = 1'b0;
                if (phase_d) begin
                    web_d = 1'b0;
                    din_d = ~pattern_d;
                end
            end
            ST_R1W0: begin
                csb_d = 1'b0;
                if (phase_d) begin
                    web_d = 1'b0;
                    din_d = pattern_d;
                end
            end
            ST_R0: begin
                csb_d = 1'b0;
            end
            default: begin
                csb_d = 1'b1;
            end
        endcase
    end

    // Read-compare pipe: one entry per issued read, retired READ_LATENCY cycles later.
    always_comb begin
        rd_now  = (state_q == ST_R0) ||
                  (((state_q == ST_R0W1) || (state_q == ST_R1W0)) && !phase_q);
        exp_now = (state_q == ST_R1W0) ? ~pattern_q : pattern_q;
        pipe_vld_d[0]  = rd_now && !abort_now && !start_now;
        pipe_exp_d[0]  = exp_now;
        pipe_addr_d[0] = addr_q;
        for (int k = 1; k < READ_LATENCY; k++) begin
            pipe_vld_d[k]  = pipe_vld_q[k-1] && !abort_now && !start_now;
            pipe_exp_d[k]  = pipe_exp_q[k-1];
            pipe_addr_d[k] = pipe_addr_q[k-1];
        end
    end

    // Per-macro compare and result accumulation.
    always_comb begin
        cmp_vld  = pipe_vld_q[READ_LATENCY-1] && !abort_now;
        miss     = '0;
        miss_cnt = '0;
        for (int i = 0; i < NUM_SRAMS; i++) begin
            miss[i]  = cmp_vld &&
                       (sram_dout[i*DATA_WIDTH +: DATA_WIDTH] != pipe_exp_q[READ_LATENCY-1]);
            miss_cnt = miss_cnt + 17'(miss[i]);
        end
        err_sum     = {1'b0, err_q} + miss_cnt;
        fail_vec_d  = fail_vec_q | miss;
        fail_addr_d = fail_addr_q;
        err_d       = err_sum[16] ? 16'hFFFF : err_sum[15:0];
        if ((|miss) && (fail_vec_q == '0)) begin
            fail_addr_d = pipe_addr_q[READ_LATENCY-1];
        end
        if (start_now) begin
            fail_vec_d  = '0;
            fail_addr_d = '0;
            err_d       = '0;
        end
    end

    // State, port and result registers with synchronous reset.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            phase_q     <= 1'b0;
            mode_q      <= 1'b0;
            pattern_q   <= '0;
            drain_q     <= '0;
            csb_q       <= 1'b1;
            web_q       <= 1'b1;
            din_q       <= '0;
            pipe_vld_q  <= '0;
            for (int k = 0; k < READ_LATENCY; k++) begin
                pipe_exp_q[k]  <= '0;
                pipe_addr_q[k] <= '0;
            end
            fail_vec_q  <= '0;
            fail_addr_q <= '0;
            err_q       <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            phase_q     <= phase_d;
            mode_q      <= mode_d;
            pattern_q   <= pattern_d;
            drain_q     <= drain_d;
            csb_q       <= csb_d;
            web_q       <= web_d;
            din_q       <= din_d;
            pipe_vld_q  <= pipe_vld_d;
            for (int k = 0; k < READ_LATENCY; k++) begin
                pipe_exp_q[k]  <= pipe_exp_d[k];
                pipe_addr_q[k] <= pipe_addr_d[k];
            end
            fail_vec_q  <= fail_vec_d;
            fail_addr_q <= fail_addr_d;
            err_q       <= err_d;
        end
    end

    assign sram_csb0   = csb_q;
    assign sram_web0   = web_q;
    assign sram_addr0  = addr_q;
    assign sram_din0   = din_q;
    assign busy_o      = busy;
    assign done_o      = (state_q == ST_DONE);
    assign pass_o      = (state_q == ST_DONE) && (fail_vec_q == '0);
    assign fail_vec_o  = fail_vec_q;
    assign fail_addr_o = fail_addr_q;
    assign err_count_o = err_q;

endmodule

// File: tb/tb_sram_march_bist.sv
// Bench for sram_march_bist: behavioural SRAMs with read-fault injection and
// a scoreboard of expected SRAM ops built from the march element table.
module tb_sram_march_bist;

    localparam int AW = 4;
    localparam int DW = 8;
    localparam int NS = 2;
    localparam int L  = 1;
    localparam int D  = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic           start_i, abort_i, mode_i;
    logic [DW-1:0]  pattern_i;
    logic           csb, web;
    logic [AW-1:0]  addr;
    logic [DW-1:0]  din;
    logic [NS*DW-1:0] dout;
    logic           busy, done, pass;
    logic [NS-1:0]  fail_vec;
    logic [AW-1:0]  fail_addr;
    logic [15:0]    err_count;

    logic [DW-1:0]  mem [NS][D];
    logic           fault_en [NS];
    logic [DW-1:0]  fault_or [NS];
    logic [AW-1:0]  fault_addr;

    typedef struct packed {
        logic          csb;
        logic          web;
        logic [AW-1:0] addr;
        logic [DW-1:0] din;
    } op_t;

    op_t exp_q [$];
    int  n_tests = 0;
    int  n_fail  = 0;

    always #5 clk = ~clk;

    sram_march_bist #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_SRAMS(NS), .READ_LATENCY(L)
    ) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .start_i(start_i), .abort_i(abort_i),
        .mode_i(mode_i), .pattern_i(pattern_i),
        .sram_csb0(csb), .sram_web0(web), .sram_addr0(addr), .sram_din0(din),
        .sram_dout(dout), .busy_o(busy), .done_o(done), .pass_o(pass),
        .fail_vec_o(fail_vec), .fail_addr_o(fail_addr), .err_count_o(err_count)
    );

    // Behavioural single-port SRAMs, one-cycle read latency, optional stuck-at-1 read fault.
    always @(posedge clk) begin
        if (!csb) begin
            for (int i = 0; i < NS; i++) begin
                if (!web) mem[i][addr] <= din;
                else dout[i*DW +: DW] <= mem[i][addr] |
                    ((fault_en[i] && addr == fault_addr) ? fault_or[i] : 8'h00);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_run(input logic m, input logic [DW-1:0] p);
        for (int a = 0; a < D; a++) exp_q.push_back('{1'b0, 1'b0, 4'(a), p});
        if (m) begin
            for (int a = 0; a < D; a++) begin
                exp_q.push_back('{1'b0, 1'b1, 4'(a), 8'h00});
                exp_q.push_back('{1'b0, 1'b0, 4'(a), ~p});
            end
            for (int a = D - 1; a >= 0; a--) begin
                exp_q.push_back('{1'b0, 1'b1, 4'(a), 8'h00});
                exp_q.push_back('{1'b0, 1'b0, 4'(a), p});
            end
        end
        for (int a = 0; a < D; a++) exp_q.push_back('{1'b0, 1'b1, 4'(a), 8'h00});
        for (int k = 0; k < L; k++) exp_q.push_back('{1'b1, 1'b1, 4'h0, 8'h00});
    endtask

    task automatic check_reset_vals();
        check("rst_csb", 32'(csb), 32'd1);
        check("rst_web", 32'(web), 32'd1);
        check("rst_addr", 32'(addr), 32'd0);
        check("rst_din", 32'(din), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_pass", 32'(pass), 32'd0);
        check("rst_fail_vec", 32'(fail_vec), 32'd0);
        check("rst_fail_addr", 32'(fail_addr), 32'd0);
        check("rst_err", 32'(err_count), 32'd0);
    endtask

    task automatic check_results(input logic d, input logic ps, input logic [NS-1:0] fv,
                                 input logic [AW-1:0] fa, input logic [15:0] ec);
        check("res_done", 32'(done), 32'(d));
        check("res_pass", 32'(pass), 32'(ps));
        check("res_fail_vec", 32'(fail_vec), 32'(fv));
        check("res_fail_addr", 32'(fail_addr), 32'(fa));
        check("res_err", 32'(err_count), 32'(ec));
    endtask

    task automatic check_mem(input logic [DW-1:0] p);
        for (int i = 0; i < NS; i++)
            for (int a = 0; a < D; a++)
                check("mem", 32'(mem[i][a]), 32'(p));
    endtask

    // One run: start pulse, then compare every busy cycle's op against the scoreboard.
    task automatic run(input logic m, input logic [DW-1:0] p, input int abort_at, input int glitch_at);
        op_t e;
        int  cycles;
        exp_q.delete();
        push_run(m, p);
        @(negedge clk);
        mode_i = m; pattern_i = p; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0; mode_i = ~m; pattern_i = ~p;
        cycles = 0;
        while (busy && cycles < 1000) begin
            if (exp_q.size() == 0) begin
                check("sb_underflow", 32'(exp_q.size()), 32'd1);
                e = '{1'b1, 1'b1, 4'h0, 8'h00};
            end else begin
                e = exp_q.pop_front();
            end
            if (e.csb) begin
                check("op_idle_csb", 32'(csb), 32'd1);
            end else begin
                check("op", 32'({csb, web, addr}), 32'({1'b0, e.web, e.addr}));
                if (!e.web) check("op_din", 32'(din), 32'(e.din));
            end
            cycles++;
            start_i = (cycles == glitch_at);
            abort_i = (cycles == abort_at);
            @(negedge clk);
            if (abort_i) begin
                abort_i = 1'b0;
                check("abort_busy", 32'(busy), 32'd0);
                check("abort_csb", 32'(csb), 32'd1);
                check("abort_done", 32'(done), 32'd0);
                exp_q.delete();
            end
        end
        start_i = 1'b0;
        if (abort_at < 0) begin
            check("busy_cycles", 32'(cycles), m ? 32'(6*D + L) : 32'(2*D + L));
            check("sb_left", 32'(exp_q.size()), 32'd0);
        end
    endtask

    initial begin
        rst = 1'b1; start_i = 1'b0; abort_i = 1'b0; mode_i = 1'b0; pattern_i = '0;
        fault_addr = '0;
        for (int i = 0; i < NS; i++) begin fault_en[i] = 1'b0; fault_or[i] = '0; end
        dout = '0;
        repeat (3) @(negedge clk);
        check_reset_vals();
        rst = 1'b0;

        // mode 0, clean
        run(1'b0, 8'hA5, -1, -1);
        check_results(1'b1, 1'b1, 2'b00, 4'd0, 16'd0);
        check_mem(8'hA5);
        repeat (3) @(negedge clk);
        check("done_held", 32'(done), 32'd1);

        // mode 1, clean, with a start pulse while busy
        run(1'b1, 8'h00, -1, 10);
        check_results(1'b1, 1'b1, 2'b00, 4'd0, 16'd0);
        check_mem(8'h00);

        // mode 1, macro1 bit3 stuck-at-1 at address 5
        fault_en[1] = 1'b1; fault_or[1] = 8'h08; fault_addr = 4'd5;
        run(1'b1, 8'h00, -1, -1);
        check_results(1'b1, 1'b0, 2'b10, 4'd5, 16'd2);

        // reset in the middle of a run
        @(negedge clk);
        mode_i = 1'b1; pattern_i = 8'h55; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        repeat (30) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_vals();
        rst = 1'b0;

        // mode 0, both macros corrupted at address 9 during R0
        fault_en[0] = 1'b1; fault_en[1] = 1'b1;
        fault_or[0] = 8'h5A; fault_or[1] = 8'h5A; fault_addr = 4'd9;
        run(1'b0, 8'hA5, -1, -1);
        check_results(1'b1, 1'b0, 2'b11, 4'd9, 16'd2);

        // mode 1 with the addr-5 fault, aborted inside R1W0: results are kept
        fault_en[0] = 1'b0; fault_or[1] = 8'h08; fault_addr = 4'd5;
        run(1'b1, 8'h00, 3*D + 5, -1);
        check_results(1'b0, 1'b0, 2'b10, 4'd5, 16'd1);

        // fresh start after the abort clears everything and passes
        fault_en[1] = 1'b0;
        run(1'b1, 8'h3C, -1, -1);
        check_results(1'b1, 1'b1, 2'b00, 4'd0, 16'd0);
        check_mem(8'h3C);

        // abort in DONE is ignored
        abort_i = 1'b1;
        @(negedge clk);
        abort_i = 1'b0;
        check("abort_in_done", 32'(done), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
